// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types for the compare/select stream unit.
//   cmp_op_e     compare operation codes carried on the op port
//   cmp_state_e  IDLE / ACCUM states of the running-extremum FSM
//   is_running() true for the multi-beat running extremum ops
package cmp_pkg;

  typedef enum logic [2:0] {
    GT   = 3'd0,
    LT   = 3'd1,
    EQ   = 3'd2,
    GE   = 3'd3,
    MAX  = 3'd4,
    MIN  = 3'd5,
    RMAX = 3'd6,
    RMIN = 3'd7
  } cmp_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } cmp_state_e;

  function automatic logic is_running(cmp_op_e op);
    return (op == RMAX) || (op == RMIN);
  endfunction

endpackage

// File: rtl/cmp_core.sv
// cmp_core: combinational magnitude comparator.
//   x, y       W-bit operands
//   is_signed  1 = two's complement, 0 = unsigned
//   gt         x > y
//   eq         x == y
module cmp_core #(
  parameter int W = 6
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         is_signed,
  output logic         gt,
  output logic         eq
);

  logic [W-1:0] xs;
  logic [W-1:0] ys;

  // Flipping the sign bits maps two's complement order onto unsigned order.
  assign xs = {x[W-1] ^ is_signed, x[W-2:0]};
  assign ys = {y[W-1] ^ is_signed, y[W-2:0]};

  assign gt = xs > ys;
  assign eq = x == y;

endmodule

// File: rtl/cmp_stream_unit.sv
// cmp_stream_unit: pipelined compare/select unit with running MAX/MIN search.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; a, b operands, op, is_signed, in_last
//   out_valid/out_ready output handshake; result, flag, idx (one output register)
//
// state | meaning
// IDLE  | no burst open; single-beat ops and one-beat running bursts emit here
// ACCUM | running burst open; acc/acc_idx hold the extremum so far
module cmp_stream_unit
  import cmp_pkg::*;
#(
  parameter  int W         = 6,
  parameter  int MAX_BURST = 64,
  localparam int IW        = $clog2(MAX_BURST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  cmp_op_e       op,
  input  logic          is_signed,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic          flag,
  output logic [IW-1:0] idx
);

  localparam logic [IW-1:0] IDX_MAX = IW'(MAX_BURST - 1);

  cmp_state_e    state;
  logic [W-1:0]  acc;
  logic [IW-1:0] acc_idx;
  logic [IW-1:0] cnt;
  cmp_op_e       lop;
  logic          lsigned;

  logic gt_ab, eq_ab, gt_acc, eq_acc;
  logic accept, better, emit;
  logic [W-1:0]  n_res;
  logic          n_flag;
  logic [IW-1:0] n_idx;

  cmp_core #(.W(W)) u_ab (
    .x(a), .y(b), .is_signed(is_signed), .gt(gt_ab), .eq(eq_ab)
  );

  cmp_core #(.W(W)) u_acc (
    .x(a), .y(acc), .is_signed(lsigned), .gt(gt_acc), .eq(eq_acc)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // Strict improvement only, so ties keep the earlier index.
  assign better   = (lop == RMAX) ? gt_acc : (!gt_acc && !eq_acc);

  always_comb begin
    emit   = 1'b0;
    n_res  = '0;
    n_flag = 1'b0;
    n_idx  = '0;
    if (state == ACCUM) begin
      emit  = in_last;
      n_res = better ? a : acc;
      n_idx = better ? cnt : acc_idx;
    end else if (is_running(op)) begin
      emit  = in_last;
      n_res = a;
    end else begin
      emit = 1'b1;
      case (op)
        GT: begin n_flag = gt_ab;             n_res = {{(W-1){1'b0}}, n_flag}; end
        LT: begin n_flag = !gt_ab && !eq_ab;  n_res = {{(W-1){1'b0}}, n_flag}; end
        EQ: begin n_flag = eq_ab;             n_res = {{(W-1){1'b0}}, n_flag}; end
        GE: begin n_flag = gt_ab || eq_ab;    n_res = {{(W-1){1'b0}}, n_flag}; end
        MAX: begin n_flag = gt_ab || eq_ab;   n_res = n_flag ? a : b; end
        MIN: begin n_flag = !gt_ab;           n_res = n_flag ? a : b; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      acc_idx   <= '0;
      cnt       <= '0;
      lop       <= GT;
      lsigned   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= 1'b0;
      idx       <= '0;
    end else begin
      if (in_ready) begin
        out_valid <= accept && emit;
        if (accept && emit) begin
          result <= n_res;
          flag   <= n_flag;
          idx    <= n_idx;
        end
      end
      if (accept) begin
        if (state == IDLE) begin
          if (is_running(op) && !in_last) begin
            acc     <= a;
            acc_idx <= '0;
            cnt     <= IW'(1);
            lop     <= op;
            lsigned <= is_signed;
            state   <= ACCUM;
          end
        end else begin
          if (better) begin
            acc     <= a;
            acc_idx <= cnt;
          end
          if (in_last) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != IDX_MAX) begin
            cnt <= cnt + IW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_unit.sv
module tb_cmp_stream_unit;
  import cmp_pkg::*;

  localparam int W  = 6;
  localparam int MB = 64;
  localparam int IW = 6;

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  a = 0, b = 0;
  cmp_op_e       op = GT;
  logic          is_signed = 0;
  logic          in_last = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [W-1:0]  result;
  logic          flag;
  logic [IW-1:0] idx;

  cmp_stream_unit #(.W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .is_signed(is_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .idx(idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_rdy = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int r;
    int f;
    int i;
  } exp_t;

  exp_t    exp_q[$];
  int      burst_v[$];
  int      burst_raw[$];
  cmp_op_e bop;

  function automatic int val(input logic [W-1:0] x, input logic s);
    return s ? int'($signed(x)) : int'(x);
  endfunction

  task automatic model_accept(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input cmp_op_e top, input logic ts, input logic tl);
    exp_t e;
    int va, vb, best;
    bit first;
    first = (burst_v.size() == 0);
    if (!first || is_running(top)) begin
      if (first) begin
        bop = top;
        burst_v.push_back(val(ta, ts));
      end else begin
        // signedness of an open burst is fixed by its first beat
        burst_v.push_back(burst_raw.size() == 0 ? 0 : 0);
        burst_v[burst_v.size()-1] = val(ta, burst_raw[0]);
      end
      if (first) burst_raw.push_back(int'(ts));
      if (tl) begin
        best = 0;
        for (int i = 1; i < burst_v.size(); i++)
          if (bop == RMAX ? burst_v[i] > burst_v[best] : burst_v[i] < burst_v[best])
            best = i;
        e.r = burst_v[best] & ((1 << W) - 1);
        e.f = 0;
        e.i = (best > MB - 1) ? MB - 1 : best;
        exp_q.push_back(e);
        burst_v.delete();
        burst_raw.delete();
      end
    end else begin
      va = val(ta, ts);
      vb = val(tb_, ts);
      e.i = 0;
      case (top)
        GT:  begin e.f = int'(va >  vb); e.r = e.f; end
        LT:  begin e.f = int'(va <  vb); e.r = e.f; end
        EQ:  begin e.f = int'(va == vb); e.r = e.f; end
        GE:  begin e.f = int'(va >= vb); e.r = e.f; end
        MAX: begin e.f = int'(va >= vb); e.r = e.f ? int'(ta) : int'(tb_); end
        default: begin e.f = int'(va <= vb); e.r = e.f ? int'(ta) : int'(tb_); end
      endcase
      exp_q.push_back(e);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", int'(out_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", int'(result), e.r);
        check("flag",   int'(flag),   e.f);
        check("idx",    int'(idx),    e.i);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_beat(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input cmp_op_e top, input logic ts, input logic tl);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    a = ta; b = tb_; op = top; is_signed = ts; in_last = tl; in_valid = 1;
    while (!done) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        model_accept(ta, tb_, top, ts, tl);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        check("hs_timeout", 0, 1);
        done = 1;
      end
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    out_ready = 1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [W-1:0] hold_r;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result",    int'(result),    0);
    check("rst_flag",      int'(flag),      0);
    check("rst_idx",       int'(idx),       0);
    check("rst_in_ready",  int'(in_ready),  1);

    // GT signed vs unsigned, with 1-cycle latency check
    send_beat(6'h3F, 6'h01, GT, 1, 0);
    check("gt_latency", int'(out_valid), 1);
    send_beat(6'h3F, 6'h01, GT, 0, 0);
    check("gt_latency_u", int'(out_valid), 1);
    // EQ/GE/LT
    send_beat(6'h20, 6'h20, EQ, 1, 0);
    send_beat(6'h20, 6'h20, GE, 1, 0);
    send_beat(6'h20, 6'h20, LT, 1, 0);
    send_beat(6'h20, 6'h1F, LT, 1, 0);
    // MAX / MIN
    send_beat(6'h20, 6'h1F, MAX, 1, 0);
    send_beat(6'h05, 6'h05, MIN, 1, 0);
    idle(2);

    // RMAX signed burst -3, 5, 5, -32
    send_beat(6'h3D, 6'h00, RMAX, 1, 0);
    check("rmax_no_out1", int'(out_valid), 0);
    send_beat(6'h05, 6'h00, RMAX, 1, 0);
    check("rmax_no_out2", int'(out_valid), 0);
    send_beat(6'h05, 6'h00, GT, 0, 0);   // op/signedness ignored mid-burst
    check("rmax_no_out3", int'(out_valid), 0);
    send_beat(6'h20, 6'h00, RMIN, 0, 1);
    check("rmax_out", int'(out_valid), 1);
    idle(2);

    // Backpressure
    out_ready = 0;
    send_beat(6'h11, 6'h22, MAX, 0, 0);
    hold_r = result;
    a = 6'h30; b = 6'h02; op = GT; is_signed = 0; in_last = 0; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_stable",   int'(result),   int'(hold_r));
      check("bp_valid",    int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1;
    send_beat(6'h30, 6'h02, GT, 0, 0);
    check("bp_b2b", int'(out_valid), 1);
    idle(2);

    // Reset mid-burst
    send_beat(6'h10, 6'h00, RMIN, 0, 0);
    send_beat(6'h02, 6'h00, RMIN, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    burst_v.delete();
    burst_raw.delete();
    exp_q.delete();
    check("rst_mid_valid", int'(out_valid), 0);
    send_beat(6'h07, 6'h00, RMIN, 0, 1);
    idle(2);

    // Long burst: index saturation at MAX_BURST-1
    for (int i = 0; i < 69; i++) send_beat(6'h00, 6'h00, RMAX, 0, 0);
    send_beat(6'h3F, 6'h00, RMAX, 0, 1);
    idle(2);

    // Randomized traffic with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      cmp_op_e ro;
      ro = cmp_op_e'($urandom_range(0, 7));
      send_beat(W'($urandom), W'($urandom), ro, 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    rand_rdy = 0;
    // close any open burst so every beat is accounted for
    if (burst_v.size() != 0) send_beat(W'($urandom), 6'h00, RMAX, 0, 1);
    idle(6);
    check("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
